// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bundle: decode entry, flush and advance enable in; stall, forwarding selects,
// per-stage valid and stall counter out. Purely wires; no latency, no backpressure of its own.
interface pipe_hazard_ctrl_if #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int NUM_STAGES         = 3,
    parameter int COUNT_WIDTH        = 16
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                          en;
    logic                          id_valid;
    logic [REGFILE_ADDR_WIDTH-1:0] id_R1_addr;
    logic                          id_R1_used;
    logic [REGFILE_ADDR_WIDTH-1:0] id_R2_addr;
    logic                          id_R2_used;
    logic [REGFILE_ADDR_WIDTH-1:0] id_WR_addr;
    logic                          id_WR_en;
    logic                          id_is_load;
    logic                          flush;
    logic                          stall;
    logic [SEL_W-1:0]              fwd_sel_R1;
    logic [SEL_W-1:0]              fwd_sel_R2;
    logic [NUM_STAGES-1:0]         stage_valid;
    logic [COUNT_WIDTH-1:0]        stall_count;

    modport master (
        output en, id_valid, id_R1_addr, id_R1_used, id_R2_addr, id_R2_used,
               id_WR_addr, id_WR_en, id_is_load, flush,
        input  stall, fwd_sel_R1, fwd_sel_R2, stage_valid, stall_count
    );

    modport slave (
        input  en, id_valid, id_R1_addr, id_R1_used, id_R2_addr, id_R2_used,
               id_WR_addr, id_WR_en, id_is_load, flush,
        output stall, fwd_sel_R1, fwd_sel_R2, stage_valid, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: combinational stall and forwarding selects from tracked stages.
// Stage state advances one step per en cycle; en=0 freezes everything; stall injects a bubble into ex.
module pipe_hazard_ctrl #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int NUM_STAGES         = 3,
    parameter int LOAD_READY_STAGE   = 2,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int COUNT_WIDTH        = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    typedef struct packed {
        logic                          vld;
        logic                          wr_en;
        logic [REGFILE_ADDR_WIDTH-1:0] wr_addr;
        logic                          is_load;
    } stage_t;

    stage_t [NUM_STAGES-1:0] stage_q, stage_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [SEL_W-1:0] sel1, sel2;
    logic             haz1, haz2;
    logic             stall_w;
    logic             issue;

    function automatic logic hit(input stage_t s, input logic used,
                                 input logic [REGFILE_ADDR_WIDTH-1:0] a);
        return used && s.vld && s.wr_en && (s.wr_addr == a) &&
               !((ZERO_REG_HARDWIRED != 0) && (a == '0));
    endfunction

    // Scan oldest to youngest so the youngest matching stage overwrites earlier hits.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (hit(stage_q[i], bus.id_R1_used, bus.id_R1_addr)) begin
                sel1 = SEL_W'(i + 1);
                haz1 = stage_q[i].is_load && (i < LOAD_READY_STAGE);
            end
            if (hit(stage_q[i], bus.id_R2_used, bus.id_R2_addr)) begin
                sel2 = SEL_W'(i + 1);
                haz2 = stage_q[i].is_load && (i < LOAD_READY_STAGE);
            end
        end
    end

    assign stall_w = bus.id_valid && (haz1 || haz2) && !bus.flush;
    assign issue   = bus.id_valid && !stall_w && !bus.flush;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (bus.en) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            stage_d[0] = '0;
            if (issue) begin
                stage_d[0].vld     = 1'b1;
                stage_d[0].wr_en   = bus.id_WR_en;
                stage_d[0].wr_addr = bus.id_WR_addr;
                stage_d[0].is_load = bus.id_is_load;
            end
            if (stall_w && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.stage_valid = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bus.stage_valid[i] = stage_q[i].vld;
        end
    end

    assign bus.stall       = stall_w;
    assign bus.fwd_sel_R1  = sel1;
    assign bus.fwd_sel_R2  = sel2;
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic, scored against an
// age-ordered list model of in-flight instructions.
module tb_pipe_hazard_ctrl;
    localparam int AW  = 5;
    localparam int NS  = 3;
    localparam int LRS = 2;
    localparam int CW  = 2;
    localparam int SW  = $clog2(NS + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REGFILE_ADDR_WIDTH(AW), .NUM_STAGES(NS), .COUNT_WIDTH(CW)) bus ();

    pipe_hazard_ctrl #(
        .REGFILE_ADDR_WIDTH(AW), .NUM_STAGES(NS), .LOAD_READY_STAGE(LRS),
        .ZERO_REG_HARDWIRED(1), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit       vld;
        bit       we;
        int       addr;
        bit       ld;
    } instr_t;

    typedef struct {
        logic          stall;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic [NS-1:0] sv;
        logic [CW-1:0] cnt;
    } exp_t;

    // older[k] is the instruction k+1 slots ahead of decode (k = 0 is the youngest).
    instr_t older [NS];
    int     mcount;
    exp_t   sb [$];
    int     tests  = 0;
    int     failed = 0;

    function automatic void clear_model();
        for (int k = 0; k < NS; k++) older[k] = '{0, 0, 0, 0};
        mcount = 0;
    endfunction

    function automatic void lookup(input bit used, input int a, output int sel, output bit haz);
        sel = 0;
        haz = 0;
        if (!used || a == 0) return;
        for (int k = 0; k < NS; k++) begin
            if (older[k].vld && older[k].we && older[k].addr == a) begin
                sel = k + 1;
                haz = older[k].ld && (k < LRS);
                return;
            end
        end
    endfunction

    task automatic cyc(input bit e, input bit v, input int a1, input bit u1, input int a2,
                       input bit u2, input int wa, input bit we, input bit ld, input bit fl);
        exp_t   x;
        int     s1, s2;
        bit     h1, h2;
        instr_t nw;
        bus.en = e; bus.id_valid = v; bus.flush = fl;
        bus.id_R1_addr = AW'(a1); bus.id_R1_used = u1;
        bus.id_R2_addr = AW'(a2); bus.id_R2_used = u2;
        bus.id_WR_addr = AW'(wa); bus.id_WR_en = we; bus.id_is_load = ld;
        lookup(u1, a1, s1, h1);
        lookup(u2, a2, s2, h2);
        x.stall = v && (h1 || h2) && !fl;
        x.s1    = SW'(s1);
        x.s2    = SW'(s2);
        for (int k = 0; k < NS; k++) x.sv[k] = older[k].vld;
        x.cnt   = CW'(mcount);
        sb.push_back(x);
        @(posedge clk);
        if (e) begin
            nw = '{v && !x.stall && !fl, we, wa, ld};
            for (int k = NS - 1; k > 0; k--) older[k] = older[k-1];
            older[0] = nw;
            if (x.stall && mcount < (1 << CW) - 1) mcount++;
        end
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            tests++;
            if (bus.stall !== x.stall || bus.fwd_sel_R1 !== x.s1 || bus.fwd_sel_R2 !== x.s2 ||
                bus.stage_valid !== x.sv || bus.stall_count !== x.cnt) begin
                failed++;
                $display("FAIL cycle @%0t: got stall=%b s1=%0d s2=%0d sv=%b cnt=%0d expected stall=%b s1=%0d s2=%0d sv=%b cnt=%0d",
                         $time, bus.stall, bus.fwd_sel_R1, bus.fwd_sel_R2, bus.stage_valid,
                         bus.stall_count, x.stall, x.s1, x.s2, x.sv, x.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        bus.en = 0; bus.id_valid = 0; bus.flush = 0;
        bus.id_R1_addr = '0; bus.id_R1_used = 0; bus.id_R2_addr = '0; bus.id_R2_used = 0;
        bus.id_WR_addr = '0; bus.id_WR_en = 0; bus.id_is_load = 0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        check("reset stage_valid", int'(bus.stage_valid), 0);
        check("reset stall", int'(bus.stall), 0);
        check("reset fwd_sel_R1", int'(bus.fwd_sel_R1), 0);
        check("reset fwd_sel_R2", int'(bus.fwd_sel_R2), 0);
        check("reset stall_count", int'(bus.stall_count), 0);

        // ALU back-to-back on r3, then the read ages through every stage.
        cyc(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        repeat (4) cyc(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        // Load-use on r5 through source 2.
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
        repeat (4) cyc(1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        // Youngest of two writers to r7 wins.
        cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 1, 7, 1, 7, 1, 0, 0, 0, 0);
        // r0 writes never match, even as a load.
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        // Flush overrides a load-use hazard.
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
        cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        // Repeated load-use pairs drive the 2-bit counter into saturation.
        repeat (3) begin
            cyc(1, 1, 0, 0, 0, 0, 6, 1, 1, 0);
            repeat (3) cyc(1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        end
        check("saturated stall_count", int'(bus.stall_count), 3);
        // Freeze with a stalling instruction in decode.
        cyc(1, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        repeat (4) cyc(0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset in the middle of a cycle with a full pipeline.
        repeat (NS) cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        check("pipeline full before reset", int'(bus.stage_valid), (1 << NS) - 1);
        bus.id_valid = 0; bus.en = 0;
        #2 reset = 1'b1;
        #1;
        check("async reset stage_valid", int'(bus.stage_valid), 0);
        check("async reset stall_count", int'(bus.stall_count), 0);
        #3 reset = 1'b0;
        clear_model();
        @(posedge clk); #1;
        cyc(1, 1, 2, 1, 2, 1, 0, 0, 0, 0);
        @(negedge clk); #1;
        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
